// File: rtl/score_window_if.sv
// score_window_if: bundles the FAST score/pixel raster stream into the window
// generator and the registered 3x3 score window it hands to NMS.
//   in_valid/in_sof      : beat qualifier and start-of-frame marker
//   in_score/in_pixel    : corner score and original pixel of the beat
//   out_valid            : single-cycle window strobe
//   ref_score/adj_score  : centre score and eight packed neighbour scores
//   ref_pixel            : centre pixel value
//   out_x/out_y          : centre coordinates
// master = window generator, slave = stream source / window consumer.
interface score_window_if;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_score;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic [7:0]  ref_score;
  logic [63:0] adj_score;
  logic [7:0]  ref_pixel;
  logic [9:0]  out_x;
  logic [9:0]  out_y;

  modport master (
    input  in_valid, in_sof, in_score, in_pixel,
    output out_valid, ref_score, adj_score, ref_pixel, out_x, out_y
  );

  modport slave (
    output in_valid, in_sof, in_score, in_pixel,
    input  out_valid, ref_score, adj_score, ref_pixel, out_x, out_y
  );
endinterface

// File: rtl/score_window_generator.sv
// score_window_generator: buffers two score lines and one pixel line of a
// raster stream and emits one registered 3x3 score window per interior pixel,
// one cycle after its bottom-right neighbour is accepted.
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high
//   sw    : score_window_if.master (input stream in, window out)
module score_window_generator #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic          clk,
  input  logic          reset,
  score_window_if.master sw
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  // Position of the next beat; a sof beat overrides it to (0,0).
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-1:0] bx, by;
  logic [AW-1:0] addr;
  logic          accept, emit;

  // Line buffers: lb1 = row y-1, lb2 = row y-2, pix1 = pixels of row y-1.
  logic [7:0] lb1_q  [IMG_WIDTH];
  logic [7:0] lb2_q  [IMG_WIDTH];
  logic [7:0] pix1_q [IMG_WIDTH];
  logic [7:0] lb1_rd, lb2_rd, pix1_rd;

  // Last two columns of the window; [1] is column x-1, [0] is column x-2.
  // The third column is the data arriving with the current beat.
  logic [1:0][7:0] top_q, mid_q, bot_q;
  logic [7:0]      pix_q;

  logic        valid_q;
  logic [7:0]  ref_score_q, ref_pixel_q;
  logic [63:0] adj_score_q;
  logic [CW-1:0] out_x_q, out_y_q;

  // Beat position and next counter values.
  always_comb begin
    bx     = sw.in_sof ? '0 : col_q;
    by     = sw.in_sof ? '0 : row_q;
    col_d  = col_q;
    row_d  = row_q;
    accept = sw.in_valid;
    if (accept) begin
      if (bx == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (by == CW'(IMG_HEIGHT - 1)) ? '0 : by + CW'(1);
      end else begin
        col_d = bx + CW'(1);
        row_d = by;
      end
    end
  end

  assign addr    = AW'(bx);
  assign lb1_rd  = lb1_q[addr];
  assign lb2_rd  = lb2_q[addr];
  assign pix1_rd = pix1_q[addr];
  assign emit    = accept && (bx >= CW'(2)) && (by >= CW'(2));

  // Counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers and window shift; never cleared, emission gating hides stale data.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[addr]  <= lb1_rd;
      lb1_q[addr]  <= sw.in_score;
      pix1_q[addr] <= sw.in_pixel;
      top_q        <= {lb2_rd, top_q[1]};
      mid_q        <= {lb1_rd, mid_q[1]};
      bot_q        <= {sw.in_score, bot_q[1]};
      pix_q        <= pix1_rd;
    end
  end

  // Registered window outputs; data holds when no window is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      ref_score_q <= '0;
      adj_score_q <= '0;
      ref_pixel_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        ref_score_q <= mid_q[1];
        adj_score_q <= {top_q[0], top_q[1], lb2_rd,
                        mid_q[0], lb1_rd,
                        bot_q[0], bot_q[1], sw.in_score};
        ref_pixel_q <= pix_q;
        out_x_q     <= bx - CW'(1);
        out_y_q     <= by - CW'(1);
      end
    end
  end

  assign sw.out_valid = valid_q;
  assign sw.ref_score = ref_score_q;
  assign sw.adj_score = adj_score_q;
  assign sw.ref_pixel = ref_pixel_q;
  assign sw.out_x     = out_x_q;
  assign sw.out_y     = out_y_q;

endmodule
